// File: rtl/sirali_cikarici_pkg.sv
// Shared types and defaults for the sliced multi-cycle subtractor.
package sirali_cikarici_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 8;
    localparam int DEF_N     = DEF_WIDTH / DEF_CHUNK;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Slice counter width; at least one bit even for a single-slice build.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sirali_cikarici_parca_cikarici.sv
// Combinational CHUNK-bit subtractor slice: {b_out, d} = a - b - b_in.
module parca_cikarici #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             b_in,
    output logic [CHUNK-1:0] d,
    output logic             b_out
);

    logic [CHUNK:0] ext;

    // One extra bit catches the borrow out of the slice.
    always_comb begin
        ext   = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, b_in};
        d     = ext[CHUNK-1:0];
        b_out = ext[CHUNK];
    end

endmodule

// File: rtl/sirali_cikarici.sv
// Multi-cycle unsigned subtractor: one CHUNK-bit slice per clock, LSB first,
// with the borrow carried between slices in a register.
module sirali_cikarici
    import sirali_cikarici_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] number1,
    input  logic [WIDTH-1:0] number2,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = cnt_width(N);

    generate
        if (CHUNK <= 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("sirali_cikarici: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic [CHUNK-1:0] a_sl, b_sl, d_sl;
    logic             bout;
    int               slice_idx;

    // Select the operand slices addressed by the counter.
    always_comb begin
        slice_idx = int'(cnt_q);
        a_sl      = a_q[slice_idx*CHUNK +: CHUNK];
        b_sl      = b_q[slice_idx*CHUNK +: CHUNK];
    end

    parca_cikarici #(
        .CHUNK (CHUNK)
    ) u_parca (
        .a     (a_sl),
        .b     (b_sl),
        .b_in  (bin_q),
        .d     (d_sl),
        .b_out (bout)
    );

    // Next-state, counter, borrow chain and slice write-back.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        a_d      = a_q;
        b_d      = b_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = number1;
                    b_d      = number2;
                    cnt_d    = '0;
                    bin_d    = 1'b0;
                    diff_d   = '0;
                    borrow_d = 1'b0;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                diff_d[slice_idx*CHUNK +: CHUNK] = d_sl;
                bin_d = bout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N-1)) begin
                    // Borrow out of the top slice is the unsigned less-than flag.
                    borrow_d = bout;
                    cnt_d    = '0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and result registers; reset clears any partial result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
        end
    end

    // Operand holding registers; only meaningful after an accepted start.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_sirali_cikarici.sv
// Directed bench for sirali_cikarici with hand-computed expected results.
module tb_sirali_cikarici;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] number1;
    logic [63:0] number2;
    logic [63:0] diff;
    logic        borrow;
    logic        busy;
    logic        done;

    int checks;
    int errors;

    sirali_cikarici #(.WIDTH(64), .CHUNK(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .number1 (number1),
        .number2 (number2),
        .diff    (diff),
        .borrow  (borrow),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation and wait (bounded) for the unit to return to idle.
    // lat = edge index (start edge = 0) at which done was first seen, -1 if never.
    task automatic run_op(input logic [63:0] n1, input logic [63:0] n2,
                          output int lat, output int busy_cnt, output int done_cnt,
                          output logic [63:0] diff_at_accept);
        @(negedge clk);
        number1 = n1;
        number2 = n2;
        start   = 1'b1;
        @(posedge clk);
        #1;
        diff_at_accept = diff;
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        lat      = -1;
        @(negedge clk);
        start   = 1'b0;
        number1 = ~n1;
        number2 = ~n2;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) lat = k;
            end
            if (!busy) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        number1 = '0;
        number2 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (diff !== 64'd0) begin errors++; $display("FAIL reset_diff got %h want 0", diff); end
        checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b want 0", borrow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bc, dc;
        logic [63:0] da;
        run_op(64'd52, 64'd25, lat, bc, dc, da);
        checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
        checks++; if (bc !== 9) begin errors++; $display("FAIL basic_busy_cycles got %0d want 9", bc); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", dc); end
        checks++; if (diff !== 64'd27) begin errors++; $display("FAIL basic_diff got %h want 1b", diff); end
        checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL basic_borrow got %b want 0", borrow); end
    endtask

    task automatic test_underflow();
        int lat, bc, dc;
        logic [63:0] da;
        run_op(64'd17, 64'd60, lat, bc, dc, da);
        checks++; if (da !== 64'd0) begin errors++; $display("FAIL underflow_clear_on_start got %h want 0", da); end
        checks++; if (diff !== 64'hFFFF_FFFF_FFFF_FFD5) begin errors++; $display("FAIL underflow_diff got %h want ffffffffffffffd5", diff); end
        checks++; if (borrow !== 1'b1) begin errors++; $display("FAIL underflow_borrow got %b want 1", borrow); end
    endtask

    task automatic test_ripple();
        int lat, bc, dc;
        logic [63:0] da;
        run_op(64'h1_0000_0000, 64'd1, lat, bc, dc, da);
        checks++; if (diff !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL ripple_diff got %h want 00000000ffffffff", diff); end
        checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL ripple_borrow got %b want 0", borrow); end
        run_op(64'h8000_0000_0000_0000, 64'h0000_0000_0000_00FF, lat, bc, dc, da);
        checks++; if (diff !== 64'h7FFF_FFFF_FFFF_FF01) begin errors++; $display("FAIL ripple_top_diff got %h want 7fffffffffffff01", diff); end
        checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL ripple_top_borrow got %b want 0", borrow); end
    endtask

    task automatic test_edges();
        int lat, bc, dc;
        logic [63:0] da;
        run_op(64'd0, 64'd1, lat, bc, dc, da);
        checks++; if (diff !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL zero_minus_one_diff got %h want ffffffffffffffff", diff); end
        checks++; if (borrow !== 1'b1) begin errors++; $display("FAIL zero_minus_one_borrow got %b want 1", borrow); end
        run_op(64'd1, 64'd1, lat, bc, dc, da);
        checks++; if (diff !== 64'd0) begin errors++; $display("FAIL equal_diff got %h want 0", diff); end
        checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL equal_borrow got %b want 0", borrow); end
        run_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, lat, bc, dc, da);
        checks++; if (diff !== 64'hF012_3456_789A_BCDE) begin errors++; $display("FAIL mixed_diff got %h want f0123456789abcde", diff); end
        checks++; if (borrow !== 1'b1) begin errors++; $display("FAIL mixed_borrow got %b want 1", borrow); end
    endtask

    task automatic test_ignored_start();
        int dc;
        dc = 0;
        @(negedge clk);
        number1 = 64'd52;
        number2 = 64'd25;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        number1 = 64'd10;
        number2 = 64'd10;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) dc++;
            if (!busy) break;
        end
        checks++; if (dc !== 1) begin errors++; $display("FAIL ignored_start_done_pulses got %0d want 1", dc); end
        checks++; if (diff !== 64'd27) begin errors++; $display("FAIL ignored_start_diff got %h want 1b", diff); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_start_not_queued got busy=%b want 0", busy); end
        checks++; if (diff !== 64'd27) begin errors++; $display("FAIL idle_hold_diff got %h want 1b", diff); end
    endtask

    task automatic test_abort();
        int dc, lat, bc;
        logic [63:0] da;
        dc = 0;
        @(negedge clk);
        number1 = 64'd55;
        number2 = 64'd1;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (diff !== 64'd0) begin errors++; $display("FAIL abort_diff got %h want 0", diff); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) dc++;
        end
        checks++; if (dc !== 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles want 0", dc); end
        run_op(64'd55, 64'd1, lat, bc, dc, da);
        checks++; if (lat !== 8) begin errors++; $display("FAIL after_abort_latency got %0d want 8", lat); end
        checks++; if (diff !== 64'd54) begin errors++; $display("FAIL after_abort_diff got %h want 36", diff); end
        checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL after_abort_borrow got %b want 0", borrow); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_underflow();
        test_ripple();
        test_edges();
        test_ignored_start();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
